// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
//   arb_state_t : arbiter FSM states (free round-robin / locked to one owner)
//   rd_tag_t    : read-return tag carried alongside the BRAM read latency
//   rr_wrap     : next round-robin start index after a grant
//   oh_to_idx   : one-hot to binary index (up to 16 requesters)
package bram_arb_pkg;

    // Tag index width; bounds the supported requester count to 16.
    localparam int TAG_IDX_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

    // Index following idx, wrapping modulo n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

    // Binary index of the set bit of a one-hot vector (0 when empty).
    function automatic logic [TAG_IDX_W-1:0] oh_to_idx(input logic [15:0] oh);
        logic [TAG_IDX_W-1:0] idx;
        idx = {TAG_IDX_W{1'b0}};
        for (int i = 0; i < 16; i++) begin
            idx = idx | (oh[i] ? TAG_IDX_W'(i) : {TAG_IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter.
//   req/lock/we/addr/wdata : per-requester command, packed by requester index
//   gnt/rvalid             : one-hot accept / read-return strobes
//   rdata                  : shared read data, qualified by rvalid
// master modport: requester view; slave modport: arbiter view.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/bram_port_arbiter_rr_picker.sv
// Round-robin picker: rotates req so index rr sits at bit 0, keeps the
// lowest set bit, and rotates the result back.
//   req : request vector
//   rr  : search start index (must be < N)
//   gnt : one-hot winner, zero when no request
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr,
    output logic [N-1:0]     gnt
);
    logic [2*N-1:0] req_dbl_s;
    logic [N-1:0]   rot_s;
    logic [N-1:0]   rot_gnt_s;
    logic [2*N-1:0] gnt_dbl_s;
    logic           found_s;

    // Rotate right by rr: rot_s[j] is requester (j+rr) mod N.
    always_comb begin
        req_dbl_s = {req, req} >> rr;
        rot_s     = req_dbl_s[N-1:0];
    end

    // Keep only the first asserted bit of the rotated vector.
    always_comb begin
        rot_gnt_s = '0;
        found_s   = 1'b0;
        for (int j = 0; j < N; j++) begin
            rot_gnt_s[j] = rot_s[j] & ~found_s;
            found_s      = found_s | rot_s[j];
        end
    end

    // Rotate left by rr; the upper copy holds the unrotated winner.
    always_comb begin
        gnt_dbl_s = {rot_gnt_s, rot_gnt_s} << rr;
        gnt       = gnt_dbl_s[2*N-1:N];
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter with round-robin selection, optional burst lock
// and tagged read return.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : requester command/grant/read-return bus
//   bram_wr_en/addr/din, bram_dout : BRAM port
//   owner, locked   : current lock owner and lock state
//   lock_timeout    : one-cycle pulse in the cycle a lock is forcibly ended
// Optional macro BRAM_ARB_STATS_EN adds stat_grants / stat_stalls, one
// saturating 32-bit counter per requester each.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 4096,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_port_arbiter_if.slave    bus,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [IDX_W-1:0]      owner,
    output logic                  locked,
    output logic                  lock_timeout
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0] stat_grants,
    output logic [NUM_REQ*32-1:0] stat_stalls
`endif
);
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_t            state_r, state_next_s;
    logic [IDX_W-1:0]      owner_r, owner_next_s;
    logic [IDX_W-1:0]      rr_r, rr_next_s;
    logic [CNT_W-1:0]      cnt_r, cnt_next_s;
    logic [ADDR_WIDTH-1:0] addr_hold_r;
    logic [DATA_WIDTH-1:0] din_hold_r;
    rd_tag_t               tag_r [RD_LATENCY];

    logic [NUM_REQ-1:0]    pick_gnt_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic [NUM_REQ-1:0]    gnt_s;
    logic                  any_gnt_s;
    logic                  timeout_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_din_s;
    rd_tag_t               tag_in_s;
    rd_tag_t               tag_out_s;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req (bus.req),
        .rr  (rr_r),
        .gnt (pick_gnt_s)
    );

    // Binary index of the round-robin winner.
    always_comb begin
        pick_idx_s = IDX_W'(oh_to_idx(16'(pick_gnt_s)));
    end

    // Arbitration FSM: grant selection, lock entry/exit and lock watchdog.
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        rr_next_s    = rr_r;
        cnt_next_s   = cnt_r;
        gnt_s        = '0;
        timeout_s    = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                gnt_s = pick_gnt_s;
                if (|pick_gnt_s) begin
                    rr_next_s = IDX_W'(rr_wrap(32'(pick_idx_s), 32'(NUM_REQ)));
                    if (|(pick_gnt_s & bus.lock)) begin
                        state_next_s = ARB_LOCKED;
                        owner_next_s = pick_idx_s;
                        cnt_next_s   = '0;
                    end else begin
                        state_next_s = ARB_IDLE;
                    end
                end else begin
                    rr_next_s = rr_r;
                end
            end
            ARB_LOCKED: begin
                // Only the owner may access; its grant completes even when
                // the lock ends in this cycle.
                gnt_s[owner_r] = bus.req[owner_r];
                cnt_next_s     = cnt_r + CNT_W'(1);
                if (cnt_r == LOCK_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ARB_IDLE;
                    rr_next_s    = IDX_W'(rr_wrap(32'(owner_r), 32'(NUM_REQ)));
                    cnt_next_s   = '0;
                end else if (!bus.lock[owner_r]) begin
                    state_next_s = ARB_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ARB_LOCKED;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // AND-OR mux of the granted requester's command onto the BRAM port.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = '0;
        sel_din_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we_s   = sel_we_s | (gnt_s[i] & bus.we[i]);
            sel_addr_s = sel_addr_s | ({ADDR_WIDTH{gnt_s[i]}} & bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_din_s  = sel_din_s | ({DATA_WIDTH{gnt_s[i]}} & bus.wdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // BRAM drive: live command on a grant, otherwise hold the last address/data.
    always_comb begin
        any_gnt_s  = |gnt_s;
        bram_wr_en = any_gnt_s & sel_we_s;
        bram_addr  = any_gnt_s ? sel_addr_s : addr_hold_r;
        bram_din   = any_gnt_s ? sel_din_s : din_hold_r;
    end

    // Read tag for this cycle's access; writes carry no tag.
    always_comb begin
        tag_in_s.valid = any_gnt_s & ~sel_we_s;
        tag_in_s.idx   = oh_to_idx(16'(gnt_s));
        tag_out_s      = tag_r[RD_LATENCY-1];
    end

    // Read return: route the BRAM output to the tagged requester.
    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rvalid[i] = tag_out_s.valid & (tag_out_s.idx == TAG_IDX_W'(i));
        end
        bus.rdata = tag_out_s.valid ? bram_dout : '0;
    end

    // Status outputs.
    always_comb begin
        bus.gnt      = gnt_s;
        owner        = owner_r;
        locked       = (state_r == ARB_LOCKED);
        lock_timeout = timeout_s;
    end

    // Arbiter state, round-robin pointer, lock counter and BRAM hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            owner_r     <= '0;
            rr_r        <= '0;
            cnt_r       <= '0;
            addr_hold_r <= '0;
            din_hold_r  <= '0;
        end else begin
            state_r <= state_next_s;
            owner_r <= owner_next_s;
            rr_r    <= rr_next_s;
            cnt_r   <= cnt_next_s;
            if (any_gnt_s) begin
                addr_hold_r <= sel_addr_s;
                din_hold_r  <= sel_din_s;
            end else begin
                addr_hold_r <= addr_hold_r;
                din_hold_r  <= din_hold_r;
            end
        end
    end

    // Read-tag shift register matching the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] grants_r [NUM_REQ];
    logic [31:0] stalls_r [NUM_REQ];

    // Saturating per-requester grant and stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants_r[i] <= 32'd0;
                stalls_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants_r[i] <= grants_r[i] + {31'd0, (gnt_s[i] & (grants_r[i] != 32'hFFFF_FFFF))};
                stalls_r[i] <= stalls_r[i] + {31'd0, (bus.req[i] & ~gnt_s[i] & (stalls_r[i] != 32'hFFFF_FFFF))};
            end
        end
    end

    // Pack the counters onto the statistics ports.
    always_comb begin
        stat_grants = '0;
        stat_stalls = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*32 +: 32] = grants_r[i];
            stat_stalls[i*32 +: 32] = stalls_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter. The main instance uses
// default parameters with a BRAM model preloaded as 0xC0DE0000 | address; a
// second instance with MAX_LOCK=8 exercises the lock watchdog.
module tb_bram_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    bram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tbus ();

    logic          bram_wr_en, t_bram_wr_en;
    logic [AW-1:0] bram_addr, t_bram_addr;
    logic [DW-1:0] bram_din, t_bram_din;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] t_bram_dout;
    logic [1:0]    owner, t_owner;
    logic          locked, t_locked;
    logic          lock_timeout, t_lock_timeout;
`ifdef BRAM_ARB_STATS_EN
    logic [NR*32-1:0] stat_grants, stat_stalls, t_stat_grants, t_stat_stalls;
`endif

    assign t_bram_dout = 32'h0000_0000;

    bram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .MAX_LOCK(4096)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .bram_wr_en(bram_wr_en), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .owner(owner), .locked(locked), .lock_timeout(lock_timeout)
`ifdef BRAM_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    bram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .MAX_LOCK(8)
    ) dut_t (
        .clk(clk), .rst(rst), .bus(tbus),
        .bram_wr_en(t_bram_wr_en), .bram_addr(t_bram_addr), .bram_din(t_bram_din),
        .bram_dout(t_bram_dout), .owner(t_owner), .locked(t_locked), .lock_timeout(t_lock_timeout)
`ifdef BRAM_ARB_STATS_EN
        , .stat_grants(t_stat_grants), .stat_stalls(t_stat_stalls)
`endif
    );

    // BRAM model: unwritten words read as 0xC0DE0000 | address.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic          written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) written[i] <= 1'b0;
        end else if (bram_wr_en) begin
            mem[bram_addr]     <= bram_din;
            written[bram_addr] <= 1'b1;
        end
        bram_dout <= written[bram_addr] ? mem[bram_addr] : (32'hC0DE_0000 | {18'd0, bram_addr});
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] exp_mem(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int i, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]            = 1'b1;
        bus.we[i]             = w;
        bus.lock[i]           = l;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        bus.req  = '0;
        bus.lock = '0;
        bus.we   = '0;
    endtask

    initial begin
        clear_reqs();
        bus.addr   = '0;
        bus.wdata  = '0;
        tbus.req   = '0;
        tbus.lock  = '0;
        tbus.we    = '0;
        tbus.addr  = '0;
        tbus.wdata = '0;
        rst = 1'b1;
        repeat (2) next_cycle();

        // Reset state
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_wr_en", 32'(bram_wr_en), 32'h0);
        check("rst_addr", 32'(bram_addr), 32'h0);
        check("rst_din", bram_din, 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_timeout", 32'(lock_timeout), 32'h0);
        check("rst_t_wr_en", 32'(t_bram_wr_en), 32'h0);
        rst = 1'b0;

        // Three simultaneous reads: round-robin order 0,1,2
        drive(0, 1'b0, 1'b0, 14'h000, 32'h0);
        drive(1, 1'b0, 1'b0, 14'h480, 32'h0);
        drive(2, 1'b0, 1'b0, 14'h900, 32'h0);
        settle();
        check("t1_gnt0", 32'(bus.gnt), 32'h1);
        check("t1_addr0", 32'(bram_addr), 32'h000);
        next_cycle();
        bus.req[0] = 1'b0;
        settle();
        check("t1_gnt1", 32'(bus.gnt), 32'h2);
        check("t1_rv0", 32'(bus.rvalid), 32'h1);
        check("t1_rd0", bus.rdata, exp_mem(14'h000));
        next_cycle();
        bus.req[1] = 1'b0;
        settle();
        check("t1_gnt2", 32'(bus.gnt), 32'h4);
        check("t1_rv1", 32'(bus.rvalid), 32'h2);
        check("t1_rd1", bus.rdata, exp_mem(14'h480));
        next_cycle();
        bus.req[2] = 1'b0;
        settle();
        check("t1_gnt_none", 32'(bus.gnt), 32'h0);
        check("t1_rv2", 32'(bus.rvalid), 32'h4);
        check("t1_rd2", bus.rdata, exp_mem(14'h900));
        next_cycle();
        settle();
        check("t1_rv_idle", 32'(bus.rvalid), 32'h0);
        check("t1_rd_idle", bus.rdata, 32'h0);

        // Requester 1 locks for a 16-word scan while requester 0 waits
        drive(1, 1'b0, 1'b1, 14'h480, 32'h0);
        settle();
        check("t2_gnt_first", 32'(bus.gnt), 32'h2);
        check("t2_unlocked", 32'(locked), 32'h0);
        next_cycle();
        drive(0, 1'b0, 1'b0, 14'h010, 32'h0);
        for (int k = 1; k < 16; k++) begin
            bus.addr[1*AW +: AW] = 14'h480 + 14'(k);
            bus.lock[1] = (k != 15);
            settle();
            check($sformatf("t2_gnt_%0d", k), 32'(bus.gnt), 32'h2);
            check($sformatf("t2_locked_%0d", k), 32'(locked), 32'h1);
            check($sformatf("t2_owner_%0d", k), 32'(owner), 32'h1);
            check($sformatf("t2_rv_%0d", k), 32'(bus.rvalid), 32'h2);
            check($sformatf("t2_rd_%0d", k), bus.rdata, exp_mem(14'h480 + 14'(k - 1)));
            next_cycle();
        end
        bus.req[1]  = 1'b0;
        bus.lock[1] = 1'b0;
        settle();
        check("t2_gnt_after", 32'(bus.gnt), 32'h1);
        check("t2_released", 32'(locked), 32'h0);
        check("t2_rv_last", 32'(bus.rvalid), 32'h2);
        check("t2_rd_last", bus.rdata, exp_mem(14'h48F));
        next_cycle();
        bus.req[0] = 1'b0;
        settle();
        check("t2_rv_r0", 32'(bus.rvalid), 32'h1);
        check("t2_rd_r0", bus.rdata, exp_mem(14'h010));
        next_cycle();

        // Write then read-after-write from another requester
        drive(0, 1'b1, 1'b0, 14'h003, 32'hDEAD_BEEF);
        settle();
        check("t4_gnt_w", 32'(bus.gnt), 32'h1);
        check("t4_wr_en", 32'(bram_wr_en), 32'h1);
        check("t4_addr", 32'(bram_addr), 32'h003);
        check("t4_din", bram_din, 32'hDEAD_BEEF);
        next_cycle();
        clear_reqs();
        drive(1, 1'b0, 1'b0, 14'h003, 32'h0);
        settle();
        check("t4_gnt_r", 32'(bus.gnt), 32'h2);
        check("t4_no_rv_wr", 32'(bus.rvalid), 32'h0);
        check("t4_rd_no_wr", 32'(bram_wr_en), 32'h0);
        next_cycle();
        clear_reqs();
        settle();
        check("t4_rv", 32'(bus.rvalid), 32'h2);
        check("t4_rd", bus.rdata, 32'hDEAD_BEEF);
        check("t4_addr_hold", 32'(bram_addr), 32'h003);
        next_cycle();

        // Reset with a locking read in flight
        drive(0, 1'b0, 1'b0, 14'h001, 32'h0);
        drive(1, 1'b0, 1'b0, 14'h002, 32'h0);
        drive(2, 1'b0, 1'b1, 14'h004, 32'h0);
        rst = 1'b1;
        settle();
        check("t5_gnt_pre", 32'(bus.gnt), 32'h4);
        next_cycle();
        rst = 1'b0;
        settle();
        check("t5_no_rv", 32'(bus.rvalid), 32'h0);
        check("t5_locked", 32'(locked), 32'h0);
        check("t5_gnt_low", 32'(bus.gnt), 32'h1);
        check("t5_rdata", bus.rdata, 32'h0);
        next_cycle();
        clear_reqs();
        settle();
        check("t5_rv0", 32'(bus.rvalid), 32'h1);
        check("t5_rd0", bus.rdata, exp_mem(14'h001));
        next_cycle();

        // Lock watchdog on the MAX_LOCK=8 instance
        tbus.req  = 3'b100;
        tbus.lock = 3'b100;
        settle();
        check("t3_gnt_first", 32'(tbus.gnt), 32'h4);
        next_cycle();
        tbus.req = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            settle();
            check($sformatf("t3_gnt_%0d", k), 32'(tbus.gnt), 32'h4);
            check($sformatf("t3_to_%0d", k), 32'(t_lock_timeout), (k == 8) ? 32'h1 : 32'h0);
            check($sformatf("t3_locked_%0d", k), 32'(t_locked), 32'h1);
            next_cycle();
        end
        settle();
        check("t3_gnt_after", 32'(tbus.gnt), 32'h1);
        check("t3_to_after", 32'(t_lock_timeout), 32'h0);
        check("t3_unlocked", 32'(t_locked), 32'h0);
        next_cycle();
        tbus.req = 3'b100;
        settle();
        check("t3_relock_gnt", 32'(tbus.gnt), 32'h4);
        next_cycle();
        tbus.req  = 3'b000;
        tbus.lock = 3'b000;
        settle();
        check("t3_relocked", 32'(t_locked), 32'h1);
        check("t3_owner", 32'(t_owner), 32'h2);
        next_cycle();
        settle();
        check("t3_drop", 32'(t_locked), 32'h0);

`ifdef BRAM_ARB_STATS_EN
        // Statistics: 30 cycles of continuous requests from all three
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 14'h000, 32'h0);
        drive(1, 1'b0, 1'b0, 14'h001, 32'h0);
        drive(2, 1'b0, 1'b0, 14'h002, 32'h0);
        repeat (30) next_cycle();
        clear_reqs();
        settle();
        for (int i = 0; i < NR; i++) begin
            check($sformatf("t6_grants_%0d", i), stat_grants[i*32 +: 32], 32'd10);
            check($sformatf("t6_stalls_%0d", i), stat_stalls[i*32 +: 32], 32'd20);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
